// File: rtl/uart_command_loader.sv
// Host command loader: packs RS232 bytes into big-endian words and runs the
// sync/opcode/address protocol for upload, download and CPU reset control.
// Optional feature macro: CMD_ACK_EN (send ACK_BYTE after every completed command).
module uart_command_loader #(
  parameter int         WORD_TIMEOUT = 1000000,
  parameter logic [7:0] ACK_BYTE     = 8'h4B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  RX,
  input  logic        hasRX,
  input  logic        rxError,
  output logic [7:0]  TX,
  output logic        start_TX,
  input  logic        TX_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        force_rst,
  output logic        cmd_error
);

  typedef enum logic [3:0] {
    IDLE, OPCODE, UP_START, UP_END, UP_DATA,
    DN_START, DN_END, DN_READ, DN_WAIT, DN_SEND, DONE, ACK
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word_sr;
  logic        word_valid;
  logic [31:0] idle_timer;
  logic        drop_rx, accept, timeout, clr_bytes;

  logic [31:0] cur_addr, cur_addr_nxt, end_addr, end_addr_nxt;
  logic [31:0] tx_sr, tx_sr_nxt;
  logic [1:0]  tx_cnt, tx_cnt_nxt;
  logic        tx_hold;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic        we_nxt, re_nxt, force_nxt, err_nxt;
  logic [31:0] word_aligned, addr_plus4;

  assign word_aligned = {word_sr[31:2], 2'b00};
  assign addr_plus4   = cur_addr + 32'd4;

  assign drop_rx = (state == DN_READ) || (state == DN_WAIT) || (state == DN_SEND) ||
                   (state == DONE) || (state == ACK);
  assign accept  = hasRX && !drop_rx;
  assign timeout = (byte_cnt != 2'd0) && !accept &&
                   (idle_timer == 32'(WORD_TIMEOUT - 1));
  assign clr_bytes = rxError || ((state_nxt == DN_READ) && (state != DN_READ));

  // tx_hold masks TX_ready for the cycle right after a pulse.
  assign start_TX = ((state == DN_SEND) || (state == ACK)) && TX_ready && !tx_hold;
  assign TX = (state == ACK)     ? ACK_BYTE :
              (state == DN_SEND) ? tx_sr[31:24] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      word_sr    <= 32'd0;
      word_valid <= 1'b0;
      idle_timer <= 32'd0;
    end else if (clr_bytes || timeout) begin
      byte_cnt   <= 2'd0;
      word_valid <= 1'b0;
      idle_timer <= 32'd0;
    end else if (accept) begin
      word_sr    <= {word_sr[23:0], RX};
      byte_cnt   <= byte_cnt + 2'd1;
      word_valid <= (byte_cnt == 2'd3);
      idle_timer <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      idle_timer <= (byte_cnt != 2'd0) ? idle_timer + 32'd1 : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= 32'd0;
      end_addr  <= 32'd0;
      tx_sr     <= 32'd0;
      tx_cnt    <= 2'd0;
      tx_hold   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      force_rst <= 1'b1;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      end_addr  <= end_addr_nxt;
      tx_sr     <= tx_sr_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_hold   <= start_TX;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_we    <= we_nxt;
      mem_re    <= re_nxt;
      force_rst <= force_nxt;
      cmd_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    end_addr_nxt  = end_addr;
    tx_sr_nxt     = tx_sr;
    tx_cnt_nxt    = tx_cnt;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    force_nxt     = force_rst;
    err_nxt       = timeout;
    case (state)
      IDLE: if (word_valid && (word_sr == 32'd0)) state_nxt = OPCODE;
      OPCODE: if (word_valid) begin
        case (word_sr)
          32'd2:   state_nxt = UP_START;
          32'd3:   state_nxt = DN_START;
          32'd4:   begin force_nxt = 1'b1; state_nxt = DONE; end
          32'd5:   begin force_nxt = 1'b0; state_nxt = DONE; end
          default: begin err_nxt = 1'b1; state_nxt = IDLE; end
        endcase
      end
      UP_START, DN_START: if (word_valid) begin
        cur_addr_nxt = word_aligned;
        state_nxt    = (state == UP_START) ? UP_END : DN_END;
      end
      UP_END, DN_END: if (word_valid) begin
        end_addr_nxt = word_aligned;
        if (word_aligned <= cur_addr) state_nxt = DONE;
        else state_nxt = (state == UP_END) ? UP_DATA : DN_READ;
      end
      UP_DATA: if (word_valid) begin
        we_nxt        = 1'b1;
        mem_addr_nxt  = cur_addr;
        mem_wdata_nxt = word_sr;
        cur_addr_nxt  = addr_plus4;
        if (addr_plus4 == end_addr) state_nxt = DONE;
      end
      DN_READ: begin
        re_nxt       = 1'b1;
        mem_addr_nxt = cur_addr;
        state_nxt    = DN_WAIT;
      end
      // mem_rdata is valid the cycle after the strobe, so skip the strobe cycle.
      DN_WAIT: if (!mem_re) begin
        tx_sr_nxt  = mem_rdata;
        tx_cnt_nxt = 2'd0;
        state_nxt  = DN_SEND;
      end
      DN_SEND: if (start_TX) begin
        tx_sr_nxt  = {tx_sr[23:0], 8'h00};
        tx_cnt_nxt = tx_cnt + 2'd1;
        if (tx_cnt == 2'd3) begin
          cur_addr_nxt = addr_plus4;
          state_nxt    = (addr_plus4 == end_addr) ? DONE : DN_READ;
        end
      end
`ifdef CMD_ACK_EN
      DONE: state_nxt = ACK;
`else
      DONE: state_nxt = IDLE;
`endif
      ACK: if (start_TX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rxError) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
      we_nxt    = 1'b0;
      re_nxt    = 1'b0;
      force_nxt = force_rst;
    end
  end

endmodule
